mem_stage: RTL and testbench

//  Pipeline stage directly downstream of the execute stage. Registers the EX result, performs

---
 rtl/mem_stage.sv | 191 +++++++++++++++++++
 tb/tb_mem_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the EX result, performs LOAD/STORE accesses
// on a req/ack data-memory port with byte lanes and load extension, and feeds
// the EX forwarding path and the register-file writeback port.
module mem_stage #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  rd_EX,
  input  logic [31:0] res_EX,
  input  logic [31:0] x2_EX,
  input  logic [6:0]  opcode_EX,
  input  logic [2:0]  funct3_EX,
  output logic        stall,
  output logic [4:0]  rd_MEM,
  output logic [31:0] res_MEM,
  output logic        load_in_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  rd_WB,
  output logic [31:0] res_WB,
  output logic        mem_fault
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  // EX/MEM pipeline register
  logic [4:0]       rd_q;
  logic [31:0]      res_q;
  logic [31:0]      x2_q;
  logic [6:0]       op_q;
  logic [2:0]       f3_q;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rd_wb_q;
  logic [31:0]      res_wb_q;

  logic             is_load, is_store, mem_op, misaligned, acked;
  logic [31:0]      load_data;

  // Byte enables for an access of the given width at the given byte offset.
  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   lane_be = 4'b0001 << off;
      2'b01:   lane_be = 4'b0011 << off;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so the enabled lanes carry the value.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] x2);
    case (f3[1:0])
      2'b00:   store_data = {4{x2[7:0]}};
      2'b01:   store_data = {2{x2[15:0]}};
      default: store_data = x2;
    endcase
  endfunction

  // Select the addressed byte/half from the load word and extend it.
  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] rdata);
    logic [31:0] bw, hw;
    logic [7:0]  b;
    logic [15:0] h;
    bw = rdata >> {off, 3'b000};
    hw = rdata >> {off[1], 4'b0000};
    b  = bw[7:0];
    h  = hw[15:0];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b100:  load_extract = {24'h0, b};
      3'b101:  load_extract = {16'h0, h};
      default: load_extract = rdata;
    endcase
  endfunction

  // Decode of the instruction held in MEM and the memory-port drive.
  always_comb begin
    is_load    = (op_q == OP_LOAD);
    is_store   = (op_q == OP_STORE);
    mem_op     = is_load | is_store;
    misaligned = ((f3_q[1:0] == 2'b01) & res_q[0]) |
                 ((f3_q[1:0] == 2'b10) & (res_q[1:0] != 2'b00));
    dmem_req   = ((state_q == S_IDLE) & mem_op & ~misaligned) | (state_q == S_WAIT);
    acked      = dmem_req & dmem_ack;
    stall      = (mem_op & ~acked) | (state_q == S_FAULT);
    dmem_we    = dmem_req & is_store;
    dmem_be    = dmem_req ? lane_be(f3_q, res_q[1:0]) : 4'b0000;
    dmem_addr  = {res_q[31:2], 2'b00};
    dmem_wdata = store_data(f3_q, x2_q);
    load_data  = load_extract(f3_q, res_q[1:0], dmem_rdata);
    rd_MEM      = mem_op ? 5'd0 : rd_q;
    res_MEM     = res_q;
    load_in_MEM = is_load;
    rd_WB       = rd_wb_q;
    res_WB      = res_wb_q;
    mem_fault   = (state_q == S_FAULT);
  end

  // Access sequencing: single-cycle hit, bounded wait, sticky fault.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          if (misaligned) begin
            state_d = S_FAULT;
          end else if (!dmem_ack) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // EX/MEM register advances whenever the stage is not stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q  <= 5'd0;
      res_q <= 32'h0;
      x2_q  <= 32'h0;
      op_q  <= 7'd0;
      f3_q  <= 3'd0;
    end else if (!stall) begin
      rd_q  <= rd_EX;
      res_q <= res_EX;
      x2_q  <= x2_EX;
      op_q  <= opcode_EX;
      f3_q  <= funct3_EX;
    end
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Writeback register: bubble on stall and stores, result or load data otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_wb_q  <= 5'd0;
      res_wb_q <= 32'h0;
    end else if (stall) begin
      rd_wb_q  <= 5'd0;
    end else if (!mem_op) begin
      rd_wb_q  <= rd_q;
      res_wb_q <= res_q;
    end else if (is_load) begin
      rd_wb_q  <= rd_q;
      res_wb_q <= load_data;
    end else begin
      rd_wb_q  <= 5'd0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, store lanes, load extension,
// misalignment fault, ack timeout and asynchronous reset mid-access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  rd_EX;
  logic [31:0] res_EX, x2_EX;
  logic [6:0]  opcode_EX;
  logic [2:0]  funct3_EX;
  logic        stall;
  logic [4:0]  rd_MEM;
  logic [31:0] res_MEM;
  logic        load_in_MEM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [4:0]  rd_WB;
  logic [31:0] res_WB;
  logic        mem_fault;

  int total = 0;
  int passed = 0;

  localparam logic [6:0] OP_ALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  always #5 clk = ~clk;

  mem_stage #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_EX(rd_EX), .res_EX(res_EX), .x2_EX(x2_EX),
    .opcode_EX(opcode_EX), .funct3_EX(funct3_EX),
    .stall(stall), .rd_MEM(rd_MEM), .res_MEM(res_MEM), .load_in_MEM(load_in_MEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .rd_WB(rd_WB), .res_WB(res_WB), .mem_fault(mem_fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] res, input logic [31:0] x2);
    opcode_EX = op; funct3_EX = f3; rd_EX = rd; res_EX = res; x2_EX = x2;
  endtask

  task automatic bubble();
    drive_ex(7'd0, 3'd0, 5'd0, 32'h0, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    bubble();
    #2;
    check("rst_stall", stall, 0);
    check("rst_req", dmem_req, 0);
    check("rst_be", dmem_be, 0);
    check("rst_rd_WB", rd_WB, 0);
    check("rst_fault", mem_fault, 0);
    tick();
    reset_n = 1'b1;

    // ALU op: one cycle in MEM, then writeback
    tick();
    drive_ex(OP_ALU, 3'd0, 5'd5, 32'h1234, 32'h0);
    tick();
    bubble();
    #1;
    check("alu_rd_MEM", rd_MEM, 5);
    check("alu_res_MEM", res_MEM, 32'h1234);
    check("alu_stall", stall, 0);
    check("alu_load_in_MEM", load_in_MEM, 0);
    tick();
    check("alu_rd_WB", rd_WB, 5);
    check("alu_res_WB", res_WB, 32'h1234);

    // SB with ack on the third request cycle
    drive_ex(OP_STORE, 3'b000, 5'd7, 32'h103, 32'hAABBCCDD);
    tick();
    bubble();
    #1;
    check("sb_req", dmem_req, 1);
    check("sb_we", dmem_we, 1);
    check("sb_be", dmem_be, 4'b1000);
    check("sb_addr", dmem_addr, 32'h100);
    check("sb_wdata", dmem_wdata, 32'hDDDDDDDD);
    check("sb_stall0", stall, 1);
    check("sb_rd_MEM", rd_MEM, 0);
    tick();
    check("sb_stall1", stall, 1);
    check("sb_req_hold", dmem_req, 1);
    check("sb_be_hold", dmem_be, 4'b1000);
    tick();
    dmem_ack = 1'b1;
    #1;
    check("sb_ack_stall", stall, 0);
    check("sb_rd_WB_stalled", rd_WB, 0);
    tick();
    dmem_ack = 1'b0;
    #1;
    check("sb_done_rd_WB", rd_WB, 0);
    check("sb_done_req", dmem_req, 0);

    // LB with ack in the same cycle
    drive_ex(OP_LOAD, 3'b000, 5'd9, 32'h102, 32'h0);
    tick();
    bubble();
    dmem_ack = 1'b1;
    dmem_rdata = 32'h00800000;
    #1;
    check("lb_req", dmem_req, 1);
    check("lb_we", dmem_we, 0);
    check("lb_be", dmem_be, 4'b0100);
    check("lb_stall", stall, 0);
    check("lb_load_in_MEM", load_in_MEM, 1);
    check("lb_rd_MEM", rd_MEM, 0);
    drive_ex(OP_LOAD, 3'b100, 5'd10, 32'h102, 32'h0);
    tick();
    check("lb_rd_WB", rd_WB, 9);
    check("lb_res_WB", res_WB, 32'hFFFFFF80);
    bubble();
    tick();
    dmem_ack = 1'b0;
    check("lbu_res_WB", res_WB, 32'h00000080);
    check("lbu_rd_WB", rd_WB, 10);

    // LH / LHU on the upper half, SH and SW lanes
    drive_ex(OP_LOAD, 3'b001, 5'd11, 32'h102, 32'h0);
    tick();
    dmem_ack = 1'b1;
    dmem_rdata = 32'h80010000;
    drive_ex(OP_LOAD, 3'b101, 5'd12, 32'h102, 32'h0);
    #1;
    check("lh_be", dmem_be, 4'b1100);
    tick();
    check("lh_res_WB", res_WB, 32'hFFFF8001);
    drive_ex(OP_STORE, 3'b001, 5'd0, 32'h102, 32'h1234ABCD);
    tick();
    check("lhu_res_WB", res_WB, 32'h00008001);
    check("sh_be", dmem_be, 4'b1100);
    check("sh_wdata", dmem_wdata, 32'hABCDABCD);
    drive_ex(OP_STORE, 3'b010, 5'd0, 32'h200, 32'hCAFEBABE);
    tick();
    check("sw_be", dmem_be, 4'b1111);
    check("sw_wdata", dmem_wdata, 32'hCAFEBABE);
    check("sw_addr", dmem_addr, 32'h200);
    bubble();
    tick();
    dmem_ack = 1'b0;
    #1;
    check("sw_done_req", dmem_req, 0);

    // Misaligned LW: no request, sticky fault
    drive_ex(OP_LOAD, 3'b010, 5'd4, 32'h102, 32'h0);
    tick();
    drive_ex(OP_ALU, 3'd0, 5'd6, 32'h55, 32'h0);
    #1;
    check("mis_req", dmem_req, 0);
    check("mis_stall", stall, 1);
    tick();
    check("mis_fault", mem_fault, 1);
    check("mis_stall_f", stall, 1);
    tick();
    tick();
    check("mis_fault_hold", mem_fault, 1);
    check("mis_rd_WB", rd_WB, 0);
    check("mis_req_f", dmem_req, 0);
    reset_n = 1'b0;
    #1;
    check("mis_reset_fault", mem_fault, 0);
    check("mis_reset_stall", stall, 0);
    tick();
    reset_n = 1'b1;
    bubble();

    // LW never acknowledged: 1 issue cycle + 4 wait cycles, then fault
    drive_ex(OP_LOAD, 3'b010, 5'd8, 32'h300, 32'h0);
    tick();
    bubble();
    #1;
    check("to_req_issue", dmem_req, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_req_wait", dmem_req, 1);
      check("to_nofault_wait", mem_fault, 0);
    end
    tick();
    check("to_req_dropped", dmem_req, 0);
    check("to_fault", mem_fault, 1);
    check("to_stall", stall, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;

    // Asynchronous reset while waiting
    drive_ex(OP_LOAD, 3'b010, 5'd3, 32'h400, 32'h0);
    tick();
    bubble();
    tick();
    check("rw_req_wait", dmem_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rw_req", dmem_req, 0);
    check("rw_stall", stall, 0);
    check("rw_be", dmem_be, 0);
    check("rw_we", dmem_we, 0);
    check("rw_res_MEM", res_MEM, 0);
    check("rw_rd_WB", rd_WB, 0);
    check("rw_fault", mem_fault, 0);
    tick();
    reset_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
